// File: rtl/trng_conditioner_pkg.sv
// trng_pkg: shared types and default parameter values for the TRNG conditioner.
//   pair_state_t    - von Neumann pair FSM state (FIRST / SECOND)
//   WIDTH_DEF       - default output word width
//   DECIM_DEF       - default raw-sample decimation rate
//   REP_LIMIT_DEF   - default repetition-count health-test trip point
package trng_pkg;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } pair_state_t;

  localparam int WIDTH_DEF     = 8;
  localparam int DECIM_DEF     = 4;
  localparam int REP_LIMIT_DEF = 31;

endpackage

// File: rtl/trng_conditioner_vn_debias.sv
// vn_debias: von Neumann corrector for a strobed raw entropy bit.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   strobe   in   one raw sample is valid on bit_in this cycle
//   bit_in   in   raw sample
//   flush    in   return the pair FSM to FIRST (collection disabled)
//   bit_out  out  debiased bit (first bit of an unequal pair)
//   bit_vld  out  bit_out is a new debiased bit this cycle
module vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic bit_in,
  input  logic flush,
  output logic bit_out,
  output logic bit_vld
);

  pair_state_t state_reg;
  logic        first_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FIRST;
      first_reg <= 1'b0;
    end else if (flush) begin
      state_reg <= FIRST;
    end else if (strobe) begin
      case (state_reg)
        FIRST: begin
          first_reg <= bit_in;
          state_reg <= SECOND;
        end
        default: state_reg <= FIRST;
      endcase
    end
  end

  // The pair decision is decoded combinationally from the stored first bit
  // and the live second sample so the packer can consume it on the same
  // edge as the strobe (no extra pipeline stage).
  assign bit_out = first_reg;
  assign bit_vld = strobe && !flush && (state_reg == SECOND) && (first_reg != bit_in);

endmodule

// File: rtl/trng_conditioner.sv
// trng_conditioner: decimates the raw entropy bit, debiases it with a von
// Neumann corrector, packs WIDTH bits per word and offers words on a
// valid/ready stream.
// Optional feature: define TRNG_HEALTH_EN to build the repetition-count
// health test; otherwise health_fail is tied to 0.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   random_in    in   raw entropy bit (already synchronized)
//   enable       in   run collection; low idles and flushes partial state
//   data         out  packed random word
//   valid        out  data holds an unconsumed word
//   ready        in   consumer accepts data when valid & ready
//   health_fail  out  sticky health-test failure
module trng_conditioner
  import trng_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DECIM     = DECIM_DEF,
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             random_in,
  input  logic             enable,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             health_fail
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int BW = $clog2(WIDTH);

  if (WIDTH < 2 || DECIM < 1 || REP_LIMIT < 2) begin : g_bad_param
    $error("trng_conditioner: illegal parameter value");
  end

  // ---------------- decimation ----------------
  logic [CW-1:0] dec_cnt_reg;
  logic          strobe;

  assign strobe = enable && (dec_cnt_reg == CW'(DECIM - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       dec_cnt_reg <= '0;
    else if (!enable) dec_cnt_reg <= '0;
    else if (strobe)  dec_cnt_reg <= '0;
    else              dec_cnt_reg <= dec_cnt_reg + 1'b1;
  end

  // ---------------- debias ----------------
  logic vn_bit;
  logic vn_vld;

  vn_debias u_vn_debias (
    .clk     (clk),
    .reset   (reset),
    .strobe  (strobe),
    .bit_in  (random_in),
    .flush   (!enable),
    .bit_out (vn_bit),
    .bit_vld (vn_vld)
  );

  // ---------------- health test ----------------
  logic block;

`ifdef TRNG_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [RW-1:0] rep_reg;
  logic [RW-1:0] rep_next;
  logic          last_reg;
  logic          hf_reg;

  // rep_reg==0 means no sample seen since reset/disable, so the first
  // sample starts a fresh run of length 1.
  always_comb begin
    rep_next = rep_reg;
    if (rep_reg == '0 || random_in != last_reg) rep_next = RW'(1);
    else if (rep_reg != RW'(REP_LIMIT))         rep_next = rep_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_reg  <= '0;
      last_reg <= 1'b0;
      hf_reg   <= 1'b0;
    end else if (!enable) begin
      rep_reg <= '0;
    end else if (strobe) begin
      rep_reg  <= rep_next;
      last_reg <= random_in;
      if (rep_next == RW'(REP_LIMIT)) hf_reg <= 1'b1;
    end
  end

  assign block       = hf_reg;
  assign health_fail = hf_reg;
`else
  assign block       = 1'b0;
  assign health_fail = 1'b0;
`endif

  // ---------------- packer and output register ----------------
  logic [WIDTH-2:0] sr_reg;
  logic [BW-1:0]    bit_cnt_reg;
  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;
  logic [WIDTH-1:0] shifted;
  logic             word_done;
  logic             load;

  // Only the newest WIDTH-1 bits are kept; the completed word is those
  // bits with the arriving bit appended at the LSB.
  assign shifted   = {sr_reg, vn_bit};
  assign word_done = vn_vld && (bit_cnt_reg == BW'(WIDTH - 1));
  assign load      = word_done && (!valid_reg || ready) && !block;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_reg      <= '0;
      bit_cnt_reg <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
    end else begin
      if (!enable) begin
        sr_reg      <= '0;
        bit_cnt_reg <= '0;
      end else if (vn_vld && !word_done) begin
        sr_reg      <= shifted[WIDTH-2:0];
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end else if (load) begin
        sr_reg      <= shifted[WIDTH-2:0];
        bit_cnt_reg <= '0;
      end
      // A completed word that cannot load is dropped; the count stays at
      // WIDTH-1 so the next debiased bit retries.

      if (load) begin
        data_reg  <= shifted;
        valid_reg <= 1'b1;
      end else if (block || ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;

endmodule

// File: tb/tb_trng_conditioner.sv
// tb_trng_conditioner: directed self-checking bench for trng_conditioner.
// Main instance uses DECIM=1, WIDTH=8; a second instance uses DECIM=3 to
// exercise the decimation counter. Words handed over on valid&ready are
// checked against a queue of expected words.
module tb_trng_conditioner;

`ifdef TRNG_HEALTH_EN
  localparam logic H = 1'b1;
`else
  localparam logic H = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, random_in, enable, ready;
  logic [7:0] data;
  logic       valid, health_fail;
  logic       en3, rnd3, rdy3;
  logic [7:0] data3;
  logic       valid3, hf3;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;
  logic       seen;

  always #5 clk = ~clk;

  trng_conditioner #(.WIDTH(8), .DECIM(1), .REP_LIMIT(31)) dut (
    .clk(clk), .reset(reset), .random_in(random_in), .enable(enable),
    .data(data), .valid(valid), .ready(ready), .health_fail(health_fail)
  );

  trng_conditioner #(.WIDTH(8), .DECIM(3), .REP_LIMIT(31)) dut3 (
    .clk(clk), .reset(reset), .random_in(rnd3), .enable(en3),
    .data(data3), .valid(valid3), .ready(rdy3), .health_fail(hf3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake must consume the oldest expected word.
  always @(negedge clk) begin
    if (reset === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
      check("word_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check("word_data", {24'd0, data}, {24'd0, exp_w});
        $display("word handed over: data=%02h expected=%02h", data, exp_w);
      end
    end
  end

  task automatic step(input logic r);
    random_in = r;
    @(posedge clk);
    #1;
  endtask

  // Raw sample for edge e (1-based) giving pairs 01,10,01,10,... -> bits 0,1,0,1
  function automatic logic pat_c(input int e);
    logic pe;
    pe = (((e + 1) / 2) % 2) == 0;
    return (e % 2 == 1) ? pe : ~pe;
  endfunction

  initial begin
    reset = 1'b0; enable = 1'b0; ready = 1'b0; random_in = 1'b0;
    en3 = 1'b0; rnd3 = 1'b0; rdy3 = 1'b1;
    #2;
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", valid, 0);
    check("rst_hf", health_fail, 0);
    check("rst_data3", {24'd0, data3}, 32'd0);
    check("rst_valid3", valid3, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(0); step(0);

    // A: alternating 1,0 every clock, ready high -> 0xFF every 16 clocks
    ready = 1'b1; enable = 1'b1;
    repeat (3) exp_q.push_back(8'hFF);
    for (int e = 1; e <= 48; e++) begin
      step(e % 2 == 1);
      if (e == 15) check("A_valid_e15", valid, 0);
      if (e == 16) begin check("A_valid_e16", valid, 1); check("A_data_e16", {24'd0, data}, 32'hFF); end
      if (e == 17) check("A_valid_e17", valid, 0);
      if (e == 32) check("A_valid_e32", valid, 1);
    end
    enable = 1'b0; step(0); step(0);

    // B: equal pairs only -> no word
    enable = 1'b1; seen = 1'b0;
    for (int e = 1; e <= 64; e++) begin
      step(((e - 1) / 2) % 2 == 1);
      if (valid) seen = 1'b1;
    end
    check("B_no_valid", seen, 0);
    check("B_hf", health_fail, 0);
    enable = 1'b0; step(0); step(0);

    // C: pairs 01,10 with ready low -> 0x55 held, later word retried at handshake
    ready = 1'b0; enable = 1'b1;
    for (int e = 1; e <= 33; e++) begin
      step(pat_c(e));
      if (e == 15) check("C_valid_e15", valid, 0);
      if (e == 16 || e == 24 || e == 32 || e == 33) begin
        check("C_hold_valid", valid, 1);
        check("C_hold_data", {24'd0, data}, 32'h55);
      end
    end
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h54);
    ready = 1'b1;
    step(pat_c(34));
    check("C_reload_valid", valid, 1);
    check("C_reload_data", {24'd0, data}, 32'h54);
    step(pat_c(35));
    check("C_drained", valid, 0);
    enable = 1'b0; ready = 1'b0; step(0); step(0);

    // D: enable dropped after 5 bits (mid-pair), pending word still delivered
    enable = 1'b1;
    for (int e = 1; e <= 27; e++) begin
      step(e % 2 == 1);
      if (e == 16) check("D_word_data", {24'd0, data}, 32'hFF);
    end
    enable = 1'b0;
    repeat (3) step(0);
    check("D_held_valid", valid, 1);
    check("D_held_data", {24'd0, data}, 32'hFF);
    exp_q.push_back(8'hFF);
    ready = 1'b1;
    step(0);
    check("D_drained", valid, 0);
    exp_q.push_back(8'hAA);
    enable = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      step(~pat_c(e));
      if (e == 15) check("D_reen_e15", valid, 0);
      if (e == 16) begin check("D_reen_valid", valid, 1); check("D_reen_data", {24'd0, data}, 32'hAA); end
      if (e == 17) check("D_reen_e17", valid, 0);
    end
    enable = 1'b0; ready = 1'b0; step(0); step(0);

    // Reset asserted mid-operation with a word pending
    enable = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      step(e % 2 == 1);
      if (e == 16) check("R_pending", valid, 1);
    end
    #2 reset = 1'b0;
    #1;
    check("R_async_valid", valid, 0);
    check("R_async_data", {24'd0, data}, 32'd0);
    check("R_async_hf", health_fail, 0);
    enable = 1'b0;
    step(0);
    reset = 1'b1;
    step(0); step(0);

    // Health: stuck-at-1 source trips on the 31st sample edge
    ready = 1'b1; enable = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step(1);
      if (e == 30) check("H_hf_e30", health_fail, 0);
      if (e == 31) check("H_hf_e31", health_fail, H);
    end
    check("H_valid_stuck", valid, 0);
    enable = 1'b0; step(0); step(0);
    check("H_sticky", health_fail, H);
    enable = 1'b1; seen = 1'b0;
    if (!H) exp_q.push_back(8'hFF);
    for (int e = 1; e <= 17; e++) begin
      step(e % 2 == 1);
      if (valid) seen = 1'b1;
    end
    check("H_blocked_word", seen, !H);
    enable = 1'b0; step(0);
    #2 reset = 1'b0;
    #1 check("H_reset_clears", health_fail, 0);
    step(0);
    reset = 1'b1;
    step(0);

    // DECIM=3 instance: raw value held per 3-clock window, windows alternate 1,0
    en3 = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      rnd3 = (((e - 1) / 3) % 2) == 0;
      @(posedge clk); #1;
      if (e == 47) check("DEC3_valid_e47", valid3, 0);
      if (e == 48) begin check("DEC3_valid_e48", valid3, 1); check("DEC3_data", {24'd0, data3}, 32'hFF); end
      if (e == 49) check("DEC3_valid_e49", valid3, 0);
    end
    check("DEC3_hf", hf3, 0);
    en3 = 1'b0;
    step(0); step(0);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trng_conditioner.md
# trng_conditioner

Downstream consumer of the ring-oscillator entropy bit. Samples the synchronized `random` output at a programmable decimation rate and removes bias with a von Neumann corrector. Packs the unbiased bits into WIDTH-bit words and presents them on a valid/ready stream to the key/nonce logic. An optional repetition-count health test blocks output when the source sticks.

## Interface
- `WIDTH`, 8: output word width, ≥2
- `DECIM`, 4: sample one raw bit every DECIM clocks, ≥1
- `REP_LIMIT`, 31: consecutive identical raw samples that trip the health test, ≥2
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `random_in`  in  1  raw entropy bit, already synchronized upstream
- `enable`  in  1  run collection; low = idle and flush partial state
- `data`  out  WIDTH  packed random word
- `valid`  out  1  `data` holds an unconsumed word
- `ready`  in  1  consumer accepts `data` when `valid & ready`
- `health_fail`  out  1  sticky health-test failure

## Operation
- Reset values: `data`=0, `valid`=0, `health_fail`=0, decimation counter=0, pair state=FIRST, packer bit count=0, shift register=0.
- Decimation counter:
  - Counts 0..DECIM-1 while `enable`=1; wraps to 0.
  - A sample strobe fires on clocks where count==DECIM-1.
  - With `enable`=0, the counter is forced to 0.
- Von Neumann pair FSM, states FIRST and SECOND, advancing only on the sample strobe:
  - FIRST: store `random_in`, go to SECOND.
  - SECOND: if the stored bit ≠ `random_in`, emit the stored bit (pair 10→1, pair 01→0). If equal, emit nothing. Return to FIRST.
- Packer:
  - Each emitted bit shifts in at the LSB: `sr <= {sr[WIDTH-2:0], bit}`. The first bit of a word ends at the MSB.
  - Bit count runs 0..WIDTH-1.
  - When the WIDTH-th bit arrives and the output register is free, load {sr, bit} into `data`, set `valid`, and clear the bit count.
  - The output register is free when `valid`=0, or when `valid & ready` in that same cycle.
  - If the output register is not free, the WIDTH-th bit is dropped. The count stays at WIDTH-1 and the next emitted bit retries.
- Output handshake:
  - `data` is stable while `valid & !ready`.
  - `valid` clears on `valid & ready` unless a new word loads in the same cycle; in that case `valid` stays 1 and `data` updates.
- `enable` falling edge:
  - Next cycle: pair state=FIRST, bit count=0; the partial word is discarded.
  - The output register and `valid` are untouched and still drain through `ready`.
- Reset mid-operation returns everything to reset values immediately. In-flight words are lost.

## Timing
- The sample strobe, the pair decision and the packer update all occur at the same rising edge; there is no extra pipeline stage.
- `valid` rises on the edge that accepts the WIDTH-th debiased bit.
- Minimum latency from `enable` rising to `valid`: 2·WIDTH·DECIM clocks (every pair differs).
- Throughput is at most one word per 2·WIDTH·DECIM clocks. `ready` may be held high permanently.

## Configuration
- `TRNG_HEALTH_EN` defined:
  - A repetition counter tracks consecutive equal raw samples on each strobe. It resets to 1 on a change.
  - When it reaches REP_LIMIT, `health_fail` sets to 1 at that edge and stays set until `reset`.
  - While `health_fail`=1, no new word loads. An already-valid word is withdrawn: `valid` is forced to 0 on the next edge.
  - `enable`=0 clears the repetition counter but not `health_fail`.
- `TRNG_HEALTH_EN` undefined:
  - No repetition counter is built; `health_fail` is tied to 0.

## Structure
- Package `trng_pkg`:
  - Pair-state enum (FIRST, SECOND).
  - Default constants for WIDTH, DECIM and REP_LIMIT.
- Sub-module `vn_debias`:
  - Inputs: `clk`, `reset`, `strobe`, `bit_in`, `flush`.
  - Outputs: `bit_out`, `bit_vld`.
  - Holds the pair FSM.
- The top level holds the decimation counter, packer, output register and health test.

## Test plan
- DECIM=1, WIDTH=8, `ready`=1, `random_in` alternating 1,0 every clock → `valid` pulses 16 clocks after `enable` with `data`=0xFF, repeating every 16 clocks.
- `random_in` held per pair as 0,0,1,1,… (no unequal pairs) → `valid` never asserts; with health enabled and REP_LIMIT=31, `health_fail` stays 0.
- Pairs 01,10,01,10,… with `ready`=0 → first word 0x55 held stable on `data`. Later words are dropped until `ready`=1; the next word loads on the same edge the handshake completes and `valid` stays 1.
- `TRNG_HEALTH_EN`, DECIM=1, `random_in`=1 constant → `health_fail` rises exactly on the 31st sample edge. `valid` stays 0 afterwards and `health_fail` clears only on `reset`.
- `enable` dropped after 5 debiased bits, then re-raised → the first word after re-enable needs a full 8 new bits; an earlier pending `valid` word is still delivered.
- `reset` asserted mid-word with `valid`=1 → `valid`, `data` and `health_fail` go to 0 immediately, without waiting for a clock edge.
